// File: rtl/fsm_convert_fixed_to_float_l.sv
// fsm_convert_fixed_to_float_l
// Converts a signed two's-complement fixed-point word Q(W-1-FRAC).FRAC into an
// IEEE-754 single-precision word. The magnitude is normalised one left shift per
// clock. The mantissa is truncated (round toward zero). Zero maps to +0.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_FF       asynchronous active-high reset
//   Begin_FSM_FX start request, sampled only in IDLE
//   FIXED        W-bit signed fixed-point operand
//   ACK_FX       high while the result is valid (DONE state)
//   FLOAT        32-bit IEEE-754 result, held until the next PACK or reset
module fsm_convert_fixed_to_float_l #(
  parameter int W    = 32,
  parameter int FRAC = 26
) (
  input  logic         CLK,
  input  logic         RST_FF,
  input  logic         Begin_FSM_FX,
  input  logic [W-1:0] FIXED,
  output logic         ACK_FX,
  output logic [31:0]  FLOAT
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHKZ,
    NORM,
    PACK,
    DONE
  } state_t;

  // The biased exponent of the input's MSB weight. Each normalising shift
  // lowers it by one.
  localparam logic [8:0] EXP_INIT = 9'(127 + W - 1 - FRAC);

  state_t       state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] mag_q, mag_d;
  logic [8:0]   exp_q, exp_d;
  logic         sign_q, sign_d;
  logic         zero_q, zero_d;
  logic [31:0]  float_q, float_d;

  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state_q <= IDLE;
      x_q     <= '0;
      mag_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      float_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      float_q <= float_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    float_d = float_q;

    case (state_q)
      IDLE: begin
        if (Begin_FSM_FX) begin
          x_d     = FIXED;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // The most negative input negates to 1<<(W-1). As an unsigned value
        // that is the correct magnitude.
        sign_d  = x_q[W-1];
        mag_d   = x_q[W-1] ? ((~x_q) + {{(W-1){1'b0}}, 1'b1}) : x_q;
        exp_d   = EXP_INIT;
        zero_d  = 1'b0;
        state_d = CHKZ;
      end
      CHKZ: begin
        if (mag_q == '0) begin
          zero_d  = 1'b1;
          state_d = PACK;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q[W-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 9'd1;
        end
      end
      PACK: begin
        // The hidden one sits at mag_q[W-1]. The next 23 bits form the
        // truncated mantissa.
        if (zero_q) begin
          float_d = 32'h0;
        end else begin
          float_d = {sign_q, exp_q[7:0], mag_q[W-2:W-24]};
        end
        state_d = DONE;
      end
      DONE: begin
        if (!Begin_FSM_FX) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ACK_FX = (state_q == DONE);
  assign FLOAT  = float_q;

endmodule
